seg_scan_driver: RTL

Downstream output stage of the calculator display path: takes an 8-bit display value plus a hex/decimal mode flag and drives the board's 4-digit multiplexed seven-segment display. Decimal values are converted sequentially with a double-dabble FSM. Hex values are split into nibbles. Digits are time-multiplexed across the four anodes at a programmable refresh rate. Digit 3 always shows a mode glyph: 'H' for hex, 'd' for decimal.

---
 rtl/seg_scan_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-bit value to 4-digit multiplexed seven-segment display driver
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   value        8-bit unsigned value, sampled with value_valid
//   value_valid  single-cycle load strobe
//   display_mode 1 = hex, 0 = decimal, sampled with value_valid
//   seg          active-low segments, seg[0]=a .. seg[6]=g (registered)
//   an           active-low anodes, an[0] = rightmost digit (registered)
//   busy         high while a conversion is in flight
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       value_valid,
    input  logic       display_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    // Digit codes: 0..15 are hex digits, above that are glyphs.
    localparam logic [4:0] C_H     = 5'd16;
    localparam logic [4:0] C_D     = 5'd17;
    localparam logic [4:0] C_BLANK = 5'd18;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state;
    logic [2:0]      shift_cnt;
    logic [7:0]      bin;
    logic [11:0]     bcd;
    logic            mode;
    logic            pend_valid;
    logic [7:0]      pend_value;
    logic            pend_mode;
    logic [3:0][4:0] dig;
    logic [PW-1:0]   prescale;
    logic [1:0]      idx;

    logic [11:0]     bcd_adj;
    logic            start;
    logic [7:0]      start_value;
    logic            start_mode;

    assign busy = (state != S_IDLE);

    // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // A fresh strobe arriving on the commit cycle is the newest value, so it
    // is taken directly in preference to the older pending one.
    always_comb begin
        start       = 1'b0;
        start_value = value;
        start_mode  = display_mode;
        case (state)
            S_IDLE: start = value_valid;
            S_DONE: begin
                if (value_valid) begin
                    start = 1'b1;
                end else if (pend_valid) begin
                    start       = 1'b1;
                    start_value = pend_value;
                    start_mode  = pend_mode;
                end
            end
            default: start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_cnt  <= 3'd0;
            bin        <= 8'd0;
            bcd        <= 12'd0;
            mode       <= 1'b0;
            pend_valid <= 1'b0;
            pend_value <= 8'd0;
            pend_mode  <= 1'b0;
            dig        <= {C_D, C_BLANK, C_BLANK, 5'd0};
        end else begin
            case (state)
                S_SHIFT: begin
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    shift_cnt  <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (mode) begin
                        dig <= {C_H, C_BLANK, {1'b0, bin[7:4]}, {1'b0, bin[3:0]}};
                    end else begin
                        dig[3] <= C_D;
                        dig[2] <= (bcd[11:8] == 4'd0) ? C_BLANK : {1'b0, bcd[11:8]};
                        dig[1] <= (bcd[11:4] == 8'd0) ? C_BLANK : {1'b0, bcd[7:4]};
                        dig[0] <= {1'b0, bcd[3:0]};
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (busy && value_valid && state != S_DONE) begin
                pend_valid <= 1'b1;
                pend_value <= value;
                pend_mode  <= display_mode;
            end else if (state == S_DONE) begin
                pend_valid <= 1'b0;
            end

            if (start) begin
                bin       <= start_value;
                mode      <= start_mode;
                bcd       <= 12'd0;
                shift_cnt <= 3'd0;
                state     <= start_mode ? S_DONE : S_SHIFT;
            end
        end
    end

    function automatic logic [6:0] encode(input logic [4:0] c);
        case (c)
            5'd0:    encode = 7'b1000000;
            5'd1:    encode = 7'b1111001;
            5'd2:    encode = 7'b0100100;
            5'd3:    encode = 7'b0110000;
            5'd4:    encode = 7'b0011001;
            5'd5:    encode = 7'b0010010;
            5'd6:    encode = 7'b0000010;
            5'd7:    encode = 7'b1111000;
            5'd8:    encode = 7'b0000000;
            5'd9:    encode = 7'b0010000;
            5'd10:   encode = 7'b0001000;
            5'd11:   encode = 7'b0000011;
            5'd12:   encode = 7'b1000110;
            5'd13:   encode = 7'b0100001;
            5'd14:   encode = 7'b0000110;
            5'd15:   encode = 7'b0001110;
            C_H:     encode = 7'b0001001;
            C_D:     encode = 7'b0100001;
            default: encode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            idx      <= 2'd3;
            seg      <= 7'b1111111;
            an       <= 4'b1111;
        end else begin
            if (prescale == PW'(REFRESH_DIV - 1)) begin
                prescale <= '0;
                idx      <= idx + 2'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= encode(dig[idx]);
        end
    end

endmodule
